// File: rtl/layer_sequencer.sv
// layer_sequencer: steps the shared fully-connected neuron datapath through every
// layer of one inference (clear, operand stream, drain, capture), start/done handshake.
// Optional argmax stage over the final neuron scores: define LAYER_SEQ_ARGMAX_EN.
//
// state  | meaning
// IDLE   | waiting for start
// CLR    | clear neuron accumulators, rd_addr = 0
// ACCUM  | rd_en high, rd_addr walks 0..len-1
// DRAIN  | wait RD_LAT cycles for the trailing read data to be accumulated
// CAPT   | latch neuron outputs, advance layer or finish
// ARGMAX | scan final scores one per cycle (LAYER_SEQ_ARGMAX_EN only)
// DONE   | one-cycle completion pulse
module layer_sequencer #(
  parameter int NUM_LAYERS = 2,
  parameter int IN_LEN     = 784,
  parameter int HID_LEN    = 10,
  parameter int ADDR_BITS  = 10,
  parameter int RD_LAT     = 1
`ifdef LAYER_SEQ_ARGMAX_EN
  , parameter int NUM_NEURONS = 10,
  parameter int ACC_BITS    = 24
`endif
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(NUM_LAYERS)-1:0] layer_sel,
  output logic                          rd_en,
  output logic [ADDR_BITS-1:0]          rd_addr,
  output logic                          acc_clr,
  output logic                          acc_en,
  output logic                          activation_function,
  output logic                          capture
`ifdef LAYER_SEQ_ARGMAX_EN
  , input  logic [NUM_NEURONS*ACC_BITS-1:0] scores,
  output logic [$clog2(NUM_NEURONS)-1:0]  pred,
  output logic                            pred_valid
`endif
);

  localparam int LS_BITS = $clog2(NUM_LAYERS);
`ifdef LAYER_SEQ_ARGMAX_EN
  localparam int PRED_BITS = $clog2(NUM_NEURONS);
  localparam int CNT_REQ   = (PRED_BITS > 2) ? PRED_BITS : 2;
`else
  localparam int CNT_REQ   = 2;
`endif
  localparam int CNT_BITS = (ADDR_BITS > CNT_REQ) ? ADDR_BITS : CNT_REQ;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_ACCUM  = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_CAPT   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
`ifdef LAYER_SEQ_ARGMAX_EN
  localparam logic [2:0] S_ARGMAX = 3'd6;
  localparam logic [CNT_BITS-1:0] NN_LAST = CNT_BITS'(NUM_NEURONS - 1);
`endif

  localparam logic [CNT_BITS-1:0] IN_LAST    = CNT_BITS'(IN_LEN - 1);
  localparam logic [CNT_BITS-1:0] HID_LAST   = CNT_BITS'(HID_LEN - 1);
  localparam logic [CNT_BITS-1:0] DRAIN_LAST = CNT_BITS'(RD_LAT - 1);
  localparam logic [LS_BITS-1:0]  LAST_LAYER = LS_BITS'(NUM_LAYERS - 1);

  logic [2:0]          state;
  logic [CNT_BITS-1:0] cnt;
  logic [CNT_BITS-1:0] len_last;
  logic [RD_LAT-1:0]   rd_dly;
  logic                last_layer;
  logic                in_layer;
  logic                clear;

  // Abort outside IDLE behaves exactly like reset; in IDLE it is ignored so start wins.
  assign clear      = !rstn || (abort && (state != S_IDLE));
  assign last_layer = (layer_sel == LAST_LAYER);
  assign len_last   = (layer_sel == '0) ? IN_LAST : HID_LAST;
  assign in_layer   = (state == S_CLR) || (state == S_ACCUM) ||
                      (state == S_DRAIN) || (state == S_CAPT);

  assign busy                = (state != S_IDLE);
  assign done                = (state == S_DONE);
  assign acc_clr             = (state == S_CLR);
  assign rd_en               = (state == S_ACCUM);
  assign capture             = (state == S_CAPT);
  assign activation_function = in_layer && !last_layer;
  assign acc_en              = rd_dly[RD_LAT-1];

  // Sequencer state, layer index, operand address and the shared down-counter.
  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= S_IDLE;
      layer_sel <= '0;
      rd_addr   <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_CLR;
            layer_sel <= '0;
          end
        end
        S_CLR: begin
          cnt   <= len_last;
          state <= S_ACCUM;
        end
        S_ACCUM: begin
          if (cnt == '0) begin
            cnt   <= DRAIN_LAST;
            state <= S_DRAIN;
          end else begin
            cnt     <= cnt - CNT_BITS'(1);
            rd_addr <= rd_addr + ADDR_BITS'(1);
          end
        end
        S_DRAIN: begin
          if (cnt == '0) state <= S_CAPT;
          else           cnt   <= cnt - CNT_BITS'(1);
        end
        S_CAPT: begin
          rd_addr <= '0;
          if (!last_layer) begin
            layer_sel <= layer_sel + LS_BITS'(1);
            state     <= S_CLR;
          end else begin
`ifdef LAYER_SEQ_ARGMAX_EN
            cnt   <= NN_LAST;
            state <= S_ARGMAX;
`else
            state <= S_DONE;
`endif
          end
        end
`ifdef LAYER_SEQ_ARGMAX_EN
        S_ARGMAX: begin
          if (cnt == '0) state <= S_DONE;
          else           cnt   <= cnt - CNT_BITS'(1);
        end
`endif
        S_DONE: begin
          layer_sel <= '0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // rd_en delayed by the memory latency gives acc_en; flushed so nothing stale survives.
  always_ff @(posedge clk) begin
    if (clear) rd_dly <= '0;
    else       rd_dly <= (rd_dly << 1) | RD_LAT'(rd_en);
  end

`ifdef LAYER_SEQ_ARGMAX_EN
  logic [PRED_BITS-1:0]       scan_idx;
  logic [PRED_BITS-1:0]       best_idx;
  logic signed [ACC_BITS-1:0] best_val;
  logic signed [ACC_BITS-1:0] cur_val;
  logic                       take;

  assign cur_val    = scores[int'(scan_idx)*ACC_BITS +: ACC_BITS];
  // Strictly greater keeps the lowest index on ties; first score always seeds the max.
  assign take       = (scan_idx == '0) || (cur_val > best_val);
  assign pred_valid = (state == S_DONE);

  // Running signed maximum; pred only updates at the end of the scan.
  always_ff @(posedge clk) begin
    if (clear) begin
      scan_idx <= '0;
      best_idx <= '0;
      best_val <= '0;
      pred     <= '0;
    end else begin
      if ((state == S_IDLE) && start) pred <= '0;
      if (state == S_CAPT) scan_idx <= '0;
      if (state == S_ARGMAX) begin
        if (take) begin
          best_idx <= scan_idx;
          best_val <= cur_val;
        end
        scan_idx <= scan_idx + PRED_BITS'(1);
        if (cnt == '0) pred <= take ? scan_idx : best_idx;
      end
    end
  end
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: default instance plus a short RD_LAT=3 instance.
// Build with LAYER_SEQ_ARGMAX_EN defined to also exercise the argmax stage.
module tb_layer_sequencer;

  logic clk = 1'b0;
  logic rstn, start, abort, start3, abort3;
  logic busy, done, rd_en, acc_clr, acc_en, act, capture;
  logic [0:0] layer_sel;
  logic [9:0] rd_addr;
  logic busy3, done3, rd_en3, acc_clr3, acc_en3, act3, capture3;
  logic [0:0] layer_sel3;
  logic [9:0] rd_addr3;

  logic sel3;
  logic s_busy, s_done, s_rd_en, s_acc_clr, s_acc_en, s_act, s_cap;
  logic [0:0] s_ls;
  logic [9:0] s_addr;

  int vectors = 0;
  int miscompares = 0;

`ifdef LAYER_SEQ_ARGMAX_EN
  localparam int EXTRA = 10;
  logic [10*24-1:0] scores;
  logic [3:0] pred, pred3, s_pred;
  logic pred_valid, pred_valid3, s_pv;
  int exp_pred;
`else
  localparam int EXTRA = 0;
`endif

  always #5 clk = ~clk;

  layer_sequencer dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .busy(busy), .done(done), .layer_sel(layer_sel), .rd_en(rd_en),
    .rd_addr(rd_addr), .acc_clr(acc_clr), .acc_en(acc_en),
    .activation_function(act), .capture(capture)
`ifdef LAYER_SEQ_ARGMAX_EN
    , .scores(scores), .pred(pred), .pred_valid(pred_valid)
`endif
  );

  layer_sequencer #(.IN_LEN(5), .HID_LEN(3), .RD_LAT(3)) dut3 (
    .clk(clk), .rstn(rstn), .start(start3), .abort(abort3),
    .busy(busy3), .done(done3), .layer_sel(layer_sel3), .rd_en(rd_en3),
    .rd_addr(rd_addr3), .acc_clr(acc_clr3), .acc_en(acc_en3),
    .activation_function(act3), .capture(capture3)
`ifdef LAYER_SEQ_ARGMAX_EN
    , .scores(scores), .pred(pred3), .pred_valid(pred_valid3)
`endif
  );

  // Select which instance the schedule checker observes.
  always_comb begin
    s_busy = sel3 ? busy3 : busy;
    s_done = sel3 ? done3 : done;
    s_rd_en = sel3 ? rd_en3 : rd_en;
    s_acc_clr = sel3 ? acc_clr3 : acc_clr;
    s_acc_en = sel3 ? acc_en3 : acc_en;
    s_act = sel3 ? act3 : act;
    s_cap = sel3 ? capture3 : capture;
    s_ls = sel3 ? layer_sel3 : layer_sel;
    s_addr = sel3 ? rd_addr3 : rd_addr;
`ifdef LAYER_SEQ_ARGMAX_EN
    s_pred = sel3 ? pred3 : pred;
    s_pv = sel3 ? pred_valid3 : pred_valid;
`endif
  end

  // Launch one inference and check every cycle against the hand-derived schedule.
  task automatic run_schedule(input int l0, input int l1, input int lat, input bit use3);
    int s1, dn, e_clr, e_rd, e_addr, e_acc, e_cap, e_act, e_busy, e_done, e_ls, n_acc, done_c;
    bit x_rd;
`ifdef LAYER_SEQ_ARGMAX_EN
    int got_pred = -1;
    bit got_pv = 1'b0;
`endif
    sel3 = use3;
    s1 = 2 + l0 + lat;
    dn = s1 + 2 + l1 + lat + EXTRA;
    e_clr = 0; e_rd = 0; e_addr = 0; e_acc = 0; e_cap = 0; e_act = 0;
    e_busy = 0; e_done = 0; e_ls = 0; n_acc = 0; done_c = -1;
    if (use3) start3 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start3 = 1'b0; start = 1'b0;
    for (int c = 0; c <= dn + 2; c++) begin
      if (c > 0) @(negedge clk);
      x_rd = (c >= 1 && c <= l0) || (c >= s1 + 1 && c <= s1 + l1);
      if (s_acc_clr !== (c == 0 || c == s1)) e_clr++;
      if (s_rd_en !== x_rd) e_rd++;
      if (x_rd && s_addr !== 10'((c <= l0) ? c - 1 : c - s1 - 1)) e_addr++;
      if (s_acc_en !== ((c >= 1 + lat && c <= l0 + lat) ||
                        (c >= s1 + 1 + lat && c <= s1 + l1 + lat))) e_acc++;
      if (s_cap !== (c == l0 + lat + 1 || c == s1 + l1 + lat + 1)) e_cap++;
      if (s_act !== (c <= s1 - 1)) e_act++;
      if (s_busy !== (c <= dn)) e_busy++;
      if (s_done !== (c == dn)) e_done++;
      if (s_ls !== 1'((c >= s1 && c <= dn) ? 1 : 0)) e_ls++;
      if (s_acc_en === 1'b1) n_acc++;
      if (s_done === 1'b1 && done_c < 0) done_c = c;
`ifdef LAYER_SEQ_ARGMAX_EN
      if (c == dn) begin got_pred = int'(s_pred); got_pv = s_pv; end
      else if (s_pv !== 1'b0) e_done++;
`endif
    end
    vectors++; if (e_clr !== 0) begin miscompares++; $display("FAIL acc_clr_sched: %0d bad cycles, want 0", e_clr); end
    vectors++; if (e_rd !== 0) begin miscompares++; $display("FAIL rd_en_sched: %0d bad cycles, want 0", e_rd); end
    vectors++; if (e_addr !== 0) begin miscompares++; $display("FAIL rd_addr_sched: %0d bad cycles, want 0", e_addr); end
    vectors++; if (e_acc !== 0) begin miscompares++; $display("FAIL acc_en_sched: %0d bad cycles, want 0", e_acc); end
    vectors++; if (e_cap !== 0) begin miscompares++; $display("FAIL capture_sched: %0d bad cycles, want 0", e_cap); end
    vectors++; if (e_act !== 0) begin miscompares++; $display("FAIL activation_sched: %0d bad cycles, want 0", e_act); end
    vectors++; if (e_busy !== 0) begin miscompares++; $display("FAIL busy_sched: %0d bad cycles, want 0", e_busy); end
    vectors++; if (e_done !== 0) begin miscompares++; $display("FAIL done_sched: %0d bad cycles, want 0", e_done); end
    vectors++; if (e_ls !== 0) begin miscompares++; $display("FAIL layer_sel_sched: %0d bad cycles, want 0", e_ls); end
    vectors++; if (n_acc !== l0 + l1) begin miscompares++; $display("FAIL acc_en_count: got %0d want %0d", n_acc, l0 + l1); end
    vectors++; if (done_c !== dn) begin miscompares++; $display("FAIL done_latency: got %0d want %0d", done_c, dn); end
`ifdef LAYER_SEQ_ARGMAX_EN
    vectors++; if (got_pred !== exp_pred || got_pv !== 1'b1) begin
      miscompares++; $display("FAIL argmax_pred: got pred %0d valid %0b want pred %0d valid 1", got_pred, got_pv, exp_pred);
    end
`endif
  endtask

  task automatic test_reset;
    rstn = 1'b0; start = 1'b1; abort = 1'b1; start3 = 1'b1; abort3 = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, layer_sel, rd_en, rd_addr, acc_clr, acc_en, act, capture} !== 18'd0) begin
      miscompares++; $display("FAIL reset_outputs: got %h want 0",
        {busy, done, layer_sel, rd_en, rd_addr, acc_clr, acc_en, act, capture});
    end
    vectors++;
    if ({busy3, done3, layer_sel3, rd_en3, rd_addr3, acc_clr3, acc_en3, act3, capture3} !== 18'd0) begin
      miscompares++; $display("FAIL reset_outputs_lat3: got %h want 0",
        {busy3, done3, layer_sel3, rd_en3, rd_addr3, acc_clr3, acc_en3, act3, capture3});
    end
    rstn = 1'b1; start = 1'b0; abort = 1'b0; start3 = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || busy3 !== 1'b0) begin
      miscompares++; $display("FAIL busy_after_reset: got %b%b want 00", busy, busy3);
    end
  endtask

  task automatic test_nominal;
    run_schedule(784, 10, 1, 1'b0);
  endtask

  task automatic test_rd_lat3;
    run_schedule(5, 3, 3, 1'b1);
  endtask

  task automatic test_abort;
    int n_bad;
    bit found = 1'b0;
    sel3 = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (rd_en === 1'b1 && rd_addr === 10'd400 && layer_sel === 1'b0) found = 1'b1;
      else @(negedge clk);
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL abort_reach_addr400: not reached in 1000 cycles"); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++;
    if ({busy, done, layer_sel, rd_en, rd_addr, acc_clr, acc_en, act, capture} !== 18'd0) begin
      miscompares++; $display("FAIL abort_outputs: got %h want 0",
        {busy, done, layer_sel, rd_en, rd_addr, acc_clr, acc_en, act, capture});
    end
    n_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || capture !== 1'b0 || acc_en !== 1'b0) n_bad++;
    end
    abort = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (busy !== 1'b0) n_bad++;
    end
    vectors++;
    if (n_bad !== 0) begin miscompares++; $display("FAIL abort_quiet: %0d bad cycles, want 0", n_bad); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    vectors++;
    if (acc_clr !== 1'b1 || busy !== 1'b1) begin
      miscompares++; $display("FAIL abort_start_idle: got clr %b busy %b want 1 1", acc_clr, busy);
    end
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0 || rd_en !== 1'b0 || acc_en !== 1'b0 || rd_addr !== 10'd0) begin
      miscompares++; $display("FAIL abort_flush: got busy %b rd_en %b acc_en %b addr %0d want 0 0 0 0",
        busy, rd_en, acc_en, rd_addr);
    end
    @(negedge clk);
    run_schedule(784, 10, 1, 1'b0);
  endtask

  task automatic test_back_to_back;
    int clr_t[3];
    int done_t[2];
    int n_clr = 0, n_done = 0;
    logic busy_801 = 1'bx;
    sel3 = 1'b0;
    clr_t = '{-1, -1, -1};
    done_t = '{-1, -1};
    start = 1'b1;
    for (int c = 0; c <= 1620; c++) begin
      @(negedge clk);
      if (acc_clr === 1'b1 && layer_sel === 1'b0) begin
        if (n_clr < 3) clr_t[n_clr] = c;
        n_clr++;
      end
      if (done === 1'b1) begin
        if (n_done < 2) done_t[n_done] = c;
        n_done++;
        if (n_done == 2) start = 1'b0;
      end
      if (c == 801) busy_801 = busy;
    end
    start = 1'b0;
    vectors++; if (done_t[0] !== 800) begin miscompares++; $display("FAIL b2b_done1: got %0d want 800", done_t[0]); end
    vectors++; if (busy_801 !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_gap: got busy %b want 0", busy_801); end
    vectors++; if (clr_t[1] !== 802) begin miscompares++; $display("FAIL b2b_clr2: got %0d want 802", clr_t[1]); end
    vectors++; if (done_t[1] !== 1602) begin miscompares++; $display("FAIL b2b_done2: got %0d want 1602", done_t[1]); end
    vectors++; if (n_clr !== 2) begin miscompares++; $display("FAIL b2b_no_third: got %0d starts want 2", n_clr); end
  endtask

`ifdef LAYER_SEQ_ARGMAX_EN
  task automatic test_argmax;
    scores = '0;
    scores[0*24 +: 24] = 24'(5);
    scores[1*24 +: 24] = 24'(-3);
    scores[2*24 +: 24] = 24'(9);
    scores[3*24 +: 24] = 24'(9);
    exp_pred = 2;
    run_schedule(5, 3, 3, 1'b1);
    for (int i = 0; i < 10; i++) scores[i*24 +: 24] = 24'(-10 - i);
    scores[7*24 +: 24] = 24'(-2);
    exp_pred = 7;
    run_schedule(5, 3, 3, 1'b1);
  endtask
`endif

  initial begin
    sel3 = 1'b0;
`ifdef LAYER_SEQ_ARGMAX_EN
    scores = '0;
    exp_pred = 0;
`endif
    test_reset();
    test_nominal();
    test_rd_lat3();
    test_abort();
    test_back_to_back();
`ifdef LAYER_SEQ_ARGMAX_EN
    test_argmax();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
